// File: rtl/reg_bank_pkg.sv
// Shared sizing, types and reset value for the 8x16 register bank.
// Bypass forwarding in the top level is enabled by defining REG_BANK_WRITE_BYPASS_EN.
package reg_bank_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int SEL_W    = 3;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  sel_t;

  localparam data_t RESET_VAL = '0;

endpackage

// File: rtl/reg_cell.sv
// One enable-load register with a synchronous active-low clear.
// The clear has priority over the load.
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int W = reg_bank_pkg::DATA_W
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      q <= W'(RESET_VAL);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bank_8x16.sv
// General-purpose register file: R0..R7 plus accumulator A and result R.
// Optional same-cycle write forwarding when REG_BANK_WRITE_BYPASS_EN is defined.
module reg_bank_8x16
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = reg_bank_pkg::DATA_W,
  parameter int NUM_REGS = reg_bank_pkg::NUM_REGS,
  parameter int SEL_W    = reg_bank_pkg::SEL_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   in,
  input  logic [SEL_W-1:0]    reg_num,
  input  logic [NUM_REGS-1:0] enable,
  input  logic                enable_a,
  input  logic                enable_r,
  output logic [DATA_W-1:0]   out,
  output logic [DATA_W-1:0]   a_out,
  output logic [DATA_W-1:0]   r_out
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] r_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    reg_cell #(.W(DATA_W)) u_cell (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (enable[i]),
      .d       (in),
      .q       (regs[i])
    );
  end

  reg_cell #(.W(DATA_W)) u_acc (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (enable_a),
    .d       (in),
    .q       (a_q)
  );

  reg_cell #(.W(DATA_W)) u_res (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (enable_r),
    .d       (in),
    .q       (r_q)
  );

  // Selects with no matching register fall through to zero.
  always_comb begin
    out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg_num == SEL_W'(i)) begin
`ifdef REG_BANK_WRITE_BYPASS_EN
        out = enable[i] ? in : regs[i];
`else
        out = regs[i];
`endif
      end
    end
  end

`ifdef REG_BANK_WRITE_BYPASS_EN
  assign a_out = enable_a ? in : a_q;
  assign r_out = enable_r ? in : r_q;
`else
  assign a_out = a_q;
  assign r_out = r_q;
`endif

endmodule

// File: tb/tb_reg_bank_8x16.sv
// Scoreboard bench for reg_bank_8x16: directed scenarios then random traffic,
// checked against an array-based model of the register file.
module tb_reg_bank_8x16;

  localparam int W = 48;

  logic        clock;
  logic        reset_n;
  logic [15:0] in;
  logic [2:0]  reg_num;
  logic [7:0]  enable;
  logic        enable_a;
  logic        enable_r;
  logic [15:0] out;
  logic [15:0] a_out;
  logic [15:0] r_out;

  reg_bank_8x16 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in       (in),
    .reg_num  (reg_num),
    .enable   (enable),
    .enable_a (enable_a),
    .enable_r (enable_r),
    .out      (out),
    .a_out    (a_out),
    .r_out    (r_out)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [15:0] m_regs [8];
  logic [15:0] m_a;
  logic [15:0] m_r;

  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_cycle  = 0;

  function automatic logic [15:0] peek(input logic [2:0] sel, input logic [7:0] en,
                                       input logic [15:0] din);
    logic [15:0] v;
    v = m_regs[sel];
`ifdef REG_BANK_WRITE_BYPASS_EN
    if (en[sel]) v = din;
`endif
    return v;
  endfunction

  // One cycle: drive inputs after the edge, predict the pre-edge read, then
  // advance the model to what the next edge will store.
  task automatic drive(input logic rst_n, input logic [7:0] en, input logic ea,
                       input logic er, input logic [15:0] din, input logic [2:0] sel);
    logic [15:0] e_out, e_a, e_r;
    @(posedge clock);
    #1;
    reset_n  = rst_n;
    enable   = en;
    enable_a = ea;
    enable_r = er;
    in       = din;
    reg_num  = sel;
    e_out = peek(sel, en, din);
    e_a   = m_a;
    e_r   = m_r;
`ifdef REG_BANK_WRITE_BYPASS_EN
    if (ea) e_a = din;
    if (er) e_r = din;
`endif
    exp_q.push_back({e_out, e_a, e_r});
    if (!rst_n) begin
      foreach (m_regs[i]) m_regs[i] = 16'd0;
      m_a = 16'd0;
      m_r = 16'd0;
    end else begin
      foreach (m_regs[i]) if (en[i]) m_regs[i] = din;
      if (ea) m_a = din;
      if (er) m_r = din;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s cycle=%0d got=%h expected=%h", name, n_cycle, act, req);
  endtask

  // monitor: outputs are presented every cycle; sample mid-cycle
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out",   out,   e[47:32]);
      check("a_out", a_out, e[31:16]);
      check("r_out", r_out, e[15:0]);
      n_cycle++;
    end
  end

  initial begin
    int budget;
    logic [7:0] en_r;
    reset_n  = 1'b0;
    in       = 16'd0;
    reg_num  = 3'd0;
    enable   = 8'd0;
    enable_a = 1'b0;
    enable_r = 1'b0;
    repeat (2) @(posedge clock);
    foreach (m_regs[i]) m_regs[i] = 16'd0;
    m_a = 16'd0;
    m_r = 16'd0;

    // reset state for every select
    for (int s = 0; s < 8; s++) drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'(s));
    // accumulator and result loads
    drive(1'b1, 8'h00, 1'b1, 1'b0, 16'd45, 3'd0);
    drive(1'b1, 8'h00, 1'b0, 1'b1, 16'd92, 3'd0);
    for (int s = 0; s < 8; s++) drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'(s));
    // single register write, then read back
    drive(1'b1, 8'h01, 1'b0, 1'b0, 16'd256, 3'd0);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0);
    // multi-hot write and a non-enabled neighbour
    drive(1'b1, 8'h11, 1'b0, 1'b0, 16'd35, 3'd4);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 16'd22, 3'd5);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'd4);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0);
    // write on the selected register (bypass visible only in that build)
    drive(1'b1, 8'h04, 1'b0, 1'b0, 16'd7, 3'd2);
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'd2);
    // reset beats every enable
    drive(1'b0, 8'hFF, 1'b1, 1'b1, 16'hBEEF, 3'd3);
    for (int s = 0; s < 8; s++) drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'(s));

    // random traffic
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0:       en_r = 8'($urandom);
        1:       en_r = 8'h00;
        default: en_r = 8'h01 << $urandom_range(0, 7);
      endcase
      drive(($urandom_range(0, 40) != 0), en_r, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), 16'($urandom), 3'($urandom_range(0, 7)));
    end
    drive(1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 3'd0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
